// File: rtl/tree_spawner.sv
`default_nettype none
// ============================================================================
// Module   : tree_spawner
// Purpose  : Paces tree spawns by frame count, picks the lowest free slot,
//            pulses a one-hot deploy and confirms it through slotActive.
// Revision : 1.0  initial release
// ============================================================================
module tree_spawner #(
  parameter int         NUM_TREES     = 4,
  parameter int         BASE_INTERVAL = 45,
  parameter int         INTERVAL_STEP = 8,
  parameter int         MIN_INTERVAL  = 10,
  parameter int         ACK_TIMEOUT   = 4,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 enable,
  input  logic [1:0]           speed,
  input  logic [NUM_TREES-1:0] slotActive,
  output logic [NUM_TREES-1:0] deploy,
  output logic [7:0]           random,
  output logic [7:0]           spawnCount,
  output logic [7:0]           missedCount,
  output logic                 ackError
);

  localparam int IDX_W   = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
  localparam int MAX_INT = (BASE_INTERVAL > MIN_INTERVAL) ? BASE_INTERVAL : MIN_INTERVAL;
  localparam int CNT_W   = $clog2(MAX_INT + 1);
  localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SELECT = 3'd2,
    S_DEPLOY = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  state_t               state_q;
  logic [7:0]           lfsr_q;
  logic [7:0]           lfsr_d;
  logic [7:0]           random_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_W-1:0]     frame_q;
  logic [TO_W-1:0]      to_q;
  logic [NUM_TREES-1:0] deploy_q;
  logic [7:0]           spawn_q;
  logic [7:0]           missed_q;
  logic                 ackerr_q;

  logic [CNT_W-1:0]     load_val;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;

  function automatic logic [CNT_W-1:0] interval_for(input logic [1:0] spd);
    int v;
    v = BASE_INTERVAL - INTERVAL_STEP * int'(spd);
    if (v < MIN_INTERVAL) v = MIN_INTERVAL;
    return CNT_W'(v);
  endfunction

  // Taps 8,6,5,4: a nonzero seed can never reach the all-zero state.
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign load_val = interval_for(speed);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_TREES; i++) begin
      if (!slotActive[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      random_q <= LFSR_SEED;
      idx_q    <= '0;
      frame_q  <= '0;
      to_q     <= '0;
      deploy_q <= '0;
      spawn_q  <= 8'd0;
      missed_q <= 8'd0;
      ackerr_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      deploy_q <= '0;
      if (!enable) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            frame_q <= load_val;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (startOfFrame) begin
              frame_q <= frame_q - CNT_W'(1);
              if (frame_q == CNT_W'(1)) state_q <= S_SELECT;
            end
          end
          S_SELECT: begin
            if (free_found) begin
              random_q <= lfsr_q;
              idx_q    <= free_idx;
              deploy_q <= NUM_TREES'(1) << free_idx;
              state_q  <= S_DEPLOY;
            end else begin
              if (missed_q != 8'hFF) missed_q <= missed_q + 8'd1;
              frame_q <= load_val;
              state_q <= S_WAIT;
            end
          end
          S_DEPLOY: begin
            to_q    <= '0;
            state_q <= S_ACK;
          end
          S_ACK: begin
            if (slotActive[idx_q]) begin
              if (spawn_q != 8'hFF) spawn_q <= spawn_q + 8'd1;
              frame_q <= load_val;
              state_q <= S_WAIT;
            end else if (to_q == TO_W'(ACK_TIMEOUT - 1)) begin
              ackerr_q <= 1'b1;
              frame_q  <= load_val;
              state_q  <= S_WAIT;
            end else begin
              to_q <= to_q + TO_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign deploy      = deploy_q;
  assign random      = random_q;
  assign spawnCount  = spawn_q;
  assign missedCount = missed_q;
  assign ackError    = ackerr_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_spawner.sv
`default_nettype none
// ============================================================================
// Module   : tb_tree_spawner
// Purpose  : Self-checking bench for tree_spawner with a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_tree_spawner;

  localparam int P_SLOW = 8;
  localparam int P_FAST = 6;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       enable;
  logic [1:0] speed;
  logic [3:0] slotActive;
  logic [3:0] deploy;
  logic [7:0] random;
  logic [7:0] spawnCount;
  logic [7:0] missedCount;
  logic       ackError;

  tree_spawner dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .enable      (enable),
    .speed       (speed),
    .slotActive  (slotActive),
    .deploy      (deploy),
    .random      (random),
    .spawnCount  (spawnCount),
    .missedCount (missedCount),
    .ackError    (ackError)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] lfsr_ref;
  logic [3:0] occ;
  bit         ack_ideal;
  bit         dep_seen, multi_seen, rzero_seen;
  int         succ, miss;

  logic [3:0] dep_at    [1:15];
  logic [7:0] rnd_at    [1:15];
  logic [7:0] spawn_at  [1:15];
  logic [7:0] missed_at [1:15];
  logic [7:0] lfsr_at   [1:15];
  logic       err_at    [1:15];

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  function automatic logic [3:0] lowest_free(input logic [3:0] o);
    for (int i = 0; i < 4; i++) if (!o[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  // One clock: LFSR reference, slot model (goes active one clock after deploy), observers.
  task automatic tick();
    logic [3:0] d;
    d = deploy;
    @(posedge clk);
    if (!resetN) lfsr_ref = 8'hA5;
    else         lfsr_ref = {lfsr_ref[6:0], lfsr_ref[7] ^ lfsr_ref[5] ^ lfsr_ref[4] ^ lfsr_ref[3]};
    if (ack_ideal) occ = occ | d;
    #1;
    slotActive = occ;
    if ($countones(deploy) > 1) multi_seen = 1'b1;
    if (deploy != 4'b0) dep_seen = 1'b1;
    if (random == 8'h00) rzero_seen = 1'b1;
  endtask

  task automatic set_occ(input logic [3:0] v);
    occ        = v;
    slotActive = v;
  endtask

  // One frame of p clocks; index j holds what was seen in cycle t+j after the pulse.
  task automatic frame(input int p);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    for (int j = 1; j <= p; j++) begin
      if (j > 1) tick();
      dep_at[j]    = deploy;
      rnd_at[j]    = random;
      spawn_at[j]  = spawnCount;
      missed_at[j] = missedCount;
      lfsr_at[j]   = lfsr_ref;
      err_at[j]    = ackError;
    end
  endtask

  task automatic frames(input int n, input int p);
    repeat (n) frame(p);
  endtask

  task automatic test_reset();
    resetN = 1'b0; enable = 1'b0; speed = 2'd0; startOfFrame = 1'b0;
    ack_ideal = 1'b1; set_occ(4'b0000);
    tick(); tick();
    n_cmp++; if (deploy !== 4'b0000) begin n_fail++; $display("FAIL reset_deploy: got %b expected 0000", deploy); end
    n_cmp++; if (random !== 8'hA5) begin n_fail++; $display("FAIL reset_random: got %h expected a5", random); end
    n_cmp++; if (spawnCount !== 8'd0) begin n_fail++; $display("FAIL reset_spawn: got %0d expected 0", spawnCount); end
    n_cmp++; if (missedCount !== 8'd0) begin n_fail++; $display("FAIL reset_missed: got %0d expected 0", missedCount); end
    n_cmp++; if (ackError !== 1'b0) begin n_fail++; $display("FAIL reset_ackerr: got %b expected 0", ackError); end
    resetN = 1'b1; succ = 0; miss = 0;
  endtask

  task automatic test_first_spawn();
    enable = 1'b1; speed = 2'd0; set_occ(4'b0000);
    tick();
    dep_seen = 1'b0;
    frames(44, P_SLOW);
    n_cmp++; if (dep_seen !== 1'b0) begin n_fail++; $display("FAIL first_early: got deploy before frame 45, expected none"); end
    frame(P_SLOW); succ++;
    n_cmp++; if (dep_at[1] !== 4'b0000) begin n_fail++; $display("FAIL first_t1: got %b expected 0000", dep_at[1]); end
    n_cmp++; if (dep_at[2] !== 4'b0001) begin n_fail++; $display("FAIL first_deploy: got %b expected 0001", dep_at[2]); end
    n_cmp++; if (dep_at[3] !== 4'b0000) begin n_fail++; $display("FAIL first_pulse_len: got %b expected 0000", dep_at[3]); end
    n_cmp++; if (rnd_at[2] !== lfsr_at[1]) begin n_fail++; $display("FAIL first_random: got %h expected %h", rnd_at[2], lfsr_at[1]); end
    n_cmp++; if (spawn_at[3] !== sat8(succ - 1)) begin n_fail++; $display("FAIL first_spawn_t3: got %0d expected %0d", spawn_at[3], sat8(succ - 1)); end
    n_cmp++; if (spawn_at[4] !== sat8(succ)) begin n_fail++; $display("FAIL first_spawn_t4: got %0d expected %0d", spawn_at[4], sat8(succ)); end
  endtask

  task automatic test_speed_change();
    // The counter already running was loaded at speed 0; speed 3 applies from the next load.
    speed = 2'd3; set_occ(4'b0111);
    dep_seen = 1'b0;
    frames(44, P_SLOW);
    n_cmp++; if (dep_seen !== 1'b0) begin n_fail++; $display("FAIL speed_midwait: got deploy before frame 45, expected none"); end
    frame(P_SLOW); succ++;
    n_cmp++; if (dep_at[2] !== 4'b1000) begin n_fail++; $display("FAIL speed_deploy_a: got %b expected 1000", dep_at[2]); end
    n_cmp++; if (spawn_at[4] !== sat8(succ)) begin n_fail++; $display("FAIL speed_spawn_a: got %0d expected %0d", spawn_at[4], sat8(succ)); end
    set_occ(4'b0111);
    dep_seen = 1'b0;
    frames(20, P_SLOW);
    n_cmp++; if (dep_seen !== 1'b0) begin n_fail++; $display("FAIL speed3_early: got deploy before frame 21, expected none"); end
    frame(P_SLOW); succ++;
    n_cmp++; if (dep_at[2] !== 4'b1000) begin n_fail++; $display("FAIL speed_deploy_b: got %b expected 1000", dep_at[2]); end
    n_cmp++; if (spawn_at[4] !== sat8(succ)) begin n_fail++; $display("FAIL speed_spawn_b: got %0d expected %0d", spawn_at[4], sat8(succ)); end
  endtask

  task automatic test_all_busy();
    set_occ(4'b1111);
    for (int k = 0; k < 2; k++) begin
      dep_seen = 1'b0;
      frames(20, P_SLOW);
      frame(P_SLOW); miss++;
      n_cmp++; if (dep_seen !== 1'b0) begin n_fail++; $display("FAIL busy_deploy[%0d]: got deploy, expected none", k); end
      n_cmp++; if (missed_at[1] !== sat8(miss - 1)) begin n_fail++; $display("FAIL busy_missed_t1[%0d]: got %0d expected %0d", k, missed_at[1], sat8(miss - 1)); end
      n_cmp++; if (missed_at[2] !== sat8(miss)) begin n_fail++; $display("FAIL busy_missed_t2[%0d]: got %0d expected %0d", k, missed_at[2], sat8(miss)); end
      n_cmp++; if (spawn_at[4] !== sat8(succ)) begin n_fail++; $display("FAIL busy_spawn[%0d]: got %0d expected %0d", k, spawn_at[4], sat8(succ)); end
    end
  endtask

  task automatic test_ack_timeout();
    speed = 2'd0; ack_ideal = 1'b0; set_occ(4'b0000);
    frames(20, P_SLOW);
    frame(P_SLOW);
    n_cmp++; if (dep_at[2] !== 4'b0001) begin n_fail++; $display("FAIL to_deploy: got %b expected 0001", dep_at[2]); end
    n_cmp++; if (err_at[6] !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %b expected 0", err_at[6]); end
    n_cmp++; if (err_at[7] !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b expected 1", err_at[7]); end
    n_cmp++; if (spawn_at[7] !== sat8(succ)) begin n_fail++; $display("FAIL to_spawn: got %0d expected %0d", spawn_at[7], sat8(succ)); end
    ack_ideal = 1'b1;
    dep_seen = 1'b0;
    frames(44, P_SLOW);
    n_cmp++; if (dep_seen !== 1'b0) begin n_fail++; $display("FAIL to_next_early: got deploy before frame 45, expected none"); end
    frame(P_SLOW); succ++;
    n_cmp++; if (dep_at[2] !== 4'b0001) begin n_fail++; $display("FAIL to_next_deploy: got %b expected 0001", dep_at[2]); end
    n_cmp++; if (spawn_at[4] !== sat8(succ)) begin n_fail++; $display("FAIL to_next_spawn: got %0d expected %0d", spawn_at[4], sat8(succ)); end
    n_cmp++; if (err_at[4] !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", err_at[4]); end
  endtask

  task automatic test_enable_gap();
    set_occ(4'b0000);
    frames(10, P_SLOW);
    enable = 1'b0;
    tick();
    dep_seen = 1'b0;
    frames(50, P_SLOW);
    n_cmp++; if (dep_seen !== 1'b0) begin n_fail++; $display("FAIL gap_deploy: got deploy while disabled, expected none"); end
    n_cmp++; if (spawnCount !== sat8(succ)) begin n_fail++; $display("FAIL gap_spawn: got %0d expected %0d", spawnCount, sat8(succ)); end
    enable = 1'b1;
    tick();
    frames(44, P_SLOW);
    n_cmp++; if (dep_seen !== 1'b0) begin n_fail++; $display("FAIL gap_restart: got deploy before frame 45, expected none"); end
    frame(P_SLOW); succ++;
    n_cmp++; if (dep_at[2] !== 4'b0001) begin n_fail++; $display("FAIL gap_deploy_after: got %b expected 0001", dep_at[2]); end
    n_cmp++; if (spawn_at[4] !== sat8(succ)) begin n_fail++; $display("FAIL gap_spawn_after: got %0d expected %0d", spawn_at[4], sat8(succ)); end
  endtask

  task automatic test_reset_in_deploy();
    set_occ(4'b0000);
    frames(44, P_SLOW);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    n_cmp++; if (deploy !== 4'b0001) begin n_fail++; $display("FAIL rid_pre: got %b expected 0001", deploy); end
    resetN = 1'b0;
    tick();
    n_cmp++; if (deploy !== 4'b0000) begin n_fail++; $display("FAIL rid_deploy: got %b expected 0000", deploy); end
    n_cmp++; if (random !== 8'hA5) begin n_fail++; $display("FAIL rid_random: got %h expected a5", random); end
    n_cmp++; if (spawnCount !== 8'd0) begin n_fail++; $display("FAIL rid_spawn: got %0d expected 0", spawnCount); end
    n_cmp++; if (missedCount !== 8'd0) begin n_fail++; $display("FAIL rid_missed: got %0d expected 0", missedCount); end
    n_cmp++; if (ackError !== 1'b0) begin n_fail++; $display("FAIL rid_ackerr: got %b expected 0", ackError); end
    resetN = 1'b1; succ = 0; miss = 0;
    set_occ(4'b0000);
  endtask

  task automatic test_saturation();
    logic [3:0] o, exp_d;
    logic [7:0] held;
    speed = 2'd3;
    tick();
    held = 8'hA5; multi_seen = 1'b0; rzero_seen = 1'b0;
    for (int a = 0; a < 320; a++) begin
      o = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      set_occ(o);
      exp_d = lowest_free(o);
      frames(20, P_FAST);
      frame(P_FAST);
      if (exp_d != 4'b0000) begin succ++; held = lfsr_at[1]; end
      else miss++;
      n_cmp++; if (dep_at[1] !== 4'b0000) begin n_fail++; $display("FAIL sat_t1[%0d]: got %b expected 0000", a, dep_at[1]); end
      n_cmp++; if (dep_at[2] !== exp_d) begin n_fail++; $display("FAIL sat_deploy[%0d]: got %b expected %b (occ %b)", a, dep_at[2], exp_d, o); end
      n_cmp++; if (dep_at[3] !== 4'b0000) begin n_fail++; $display("FAIL sat_t3[%0d]: got %b expected 0000", a, dep_at[3]); end
      n_cmp++; if (rnd_at[2] !== held) begin n_fail++; $display("FAIL sat_random[%0d]: got %h expected %h", a, rnd_at[2], held); end
      n_cmp++; if (spawn_at[4] !== sat8(succ)) begin n_fail++; $display("FAIL sat_spawn[%0d]: got %0d expected %0d", a, spawn_at[4], sat8(succ)); end
      n_cmp++; if (missed_at[4] !== sat8(miss)) begin n_fail++; $display("FAIL sat_missed[%0d]: got %0d expected %0d", a, missed_at[4], sat8(miss)); end
    end
    n_cmp++; if (multi_seen !== 1'b0) begin n_fail++; $display("FAIL sat_onehot: got multi-hot deploy, expected one-hot"); end
    n_cmp++; if (rzero_seen !== 1'b0) begin n_fail++; $display("FAIL sat_random_zero: got random 00, expected nonzero"); end
    n_cmp++; if (spawnCount !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d expected 255 (%0d successes)", spawnCount, succ); end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_speed_change();
    test_all_busy();
    test_ack_timeout();
    test_enable_gap();
    test_reset_in_deploy();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
